// File: rtl/burst_mem_ctrl.sv
// rtl/burst_mem_ctrl.sv - round-robin multi-channel burst address generator
`timescale 1ns/1ps
module burst_mem_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int BURST_LEN = 4,
    parameter int NUM_CH    = 4,
    parameter int WRAP      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ptr_clr,
    output logic [NUM_CH-1:0] grant,
    output logic              cen,
    output logic              start,
    output logic              last,
    output logic [ADDR_W-1:0] addr,
    output logic              done,
    output logic [NUM_CH-1:0] full
);
    localparam int BW = $clog2(BURST_LEN);
    localparam int CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, ARM, BURST} state_t;

    state_t                           state;
    logic [NUM_CH-1:0][ADDR_W-1:0]    ptr;
    logic [ADDR_W-1:0]                base;
    logic [BW-1:0]                    beat;
    logic [CW-1:0]                    ch;
    logic [CW-1:0]                    last_served;
    logic [CW-1:0]                    pick;
    logic                             found;
    logic [NUM_CH-1:0]                eligible;
    logic [ADDR_W:0]                  sum;
    int                               idx;

    // Scan channels starting just after the last one served.
    always_comb begin
        eligible = req & ~full;
        found    = 1'b0;
        pick     = last_served;
        idx      = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last_served) + i) % NUM_CH;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
    end

    // One extra bit so the WRAP=0 end-of-space case is visible as a carry.
    assign sum = {1'b0, ptr[ch]} + (ADDR_W+1)'(BURST_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            base        <= '0;
            beat        <= '0;
            ch          <= '0;
            last_served <= CW'(NUM_CH-1);
            grant       <= '0;
            cen         <= 1'b0;
            start       <= 1'b0;
            last        <= 1'b0;
            addr        <= '0;
            done        <= 1'b0;
            full        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    grant <= '0;
                    cen   <= 1'b0;
                    start <= 1'b0;
                    last  <= 1'b0;
                    if (found) begin
                        state <= ARM;
                        ch    <= pick;
                        grant <= NUM_CH'(1) << pick;
                        cen   <= 1'b1;
                        addr  <= ptr[pick];
                    end
                end
                ARM: begin
                    base  <= ptr[ch];
                    beat  <= '0;
                    addr  <= ptr[ch];
                    start <= 1'b1;
                    last  <= 1'b0;
                    state <= BURST;
                end
                BURST: begin
                    if (beat == BW'(BURST_LEN-1)) begin
                        state       <= IDLE;
                        grant       <= '0;
                        cen         <= 1'b0;
                        start       <= 1'b0;
                        last        <= 1'b0;
                        done        <= 1'b1;
                        last_served <= ch;
                        if (WRAP == 0 && sum[ADDR_W]) begin
                            ptr[ch]  <= '0;
                            full[ch] <= 1'b1;
                        end else begin
                            ptr[ch] <= sum[ADDR_W-1:0];
                        end
                    end else begin
                        beat  <= beat + BW'(1);
                        addr  <= base + ADDR_W'(beat) + ADDR_W'(1);
                        start <= 1'b0;
                        last  <= (beat == BW'(BURST_LEN-2));
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a clear overrides a same-cycle completion update.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ptr_clr[i]) begin
                    ptr[i]  <= '0;
                    full[i] <= 1'b0;
                end
            end
        end
    end
endmodule
